cache_flush_walker: RTL and testbench

Sequencer that walks every set and way of a set-associative cache to write back dirty lines and, optionally, invalidate the whole cache. It sits beside the cache controller and drives the cache arrays' address mux and per-way clear controls. It handshakes each writeback with the bus-side writeback engine, so a flush or fence completes only when memory is coherent.

---
 rtl/cache_flush_walker.sv | 161 ++++++++++++++++
 tb/tb_cache_flush_walker.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_flush_walker.sv
`default_nettype none
// ============================================================================
// Module   : cache_flush_walker
// Brief    : Walks every set/way of a set-associative cache, hands each dirty
//            valid line to the writeback engine, optionally invalidates sets.
//            Optional WBCount output: define CACHE_FLUSH_WBCOUNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module cache_flush_walker #(
  parameter int NUMWAYS  = 4,
  parameter int SETLEN   = 9,
  parameter int NUMLINES = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               FlushStart,
  input  logic               InvalidateMode,
  input  logic [NUMWAYS-1:0] ValidWay,
  input  logic [NUMWAYS-1:0] DirtyWay,
  input  logic               WBAck,
  output logic [SETLEN-1:0]  FlushAdr,
  output logic               FlushAdrSel,
  output logic               CacheEn,
  output logic [NUMWAYS-1:0] FlushWay,
  output logic               WBReq,
  output logic               ClearDirty,
  output logic               ClearValid,
  output logic               Busy,
  output logic               FlushDone
`ifdef CACHE_FLUSH_WBCOUNT_EN
  ,
  output logic [15:0]        WBCount
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_SCAN   = 3'd2,
    S_WB     = 3'd3,
    S_FINISH = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [SETLEN-1:0]  c_LAST_SET = SETLEN'(NUMLINES - 1);
  localparam logic [SETLEN-1:0]  c_SET_ONE  = {{(SETLEN-1){1'b0}}, 1'b1};
  localparam logic [NUMWAYS-1:0] c_WAY_ONE  = {{(NUMWAYS-1){1'b0}}, 1'b1};

  state_t             r_state;
  state_t             w_next;
  logic [SETLEN-1:0]  r_set;
  logic [NUMWAYS-1:0] r_pending;
  logic               r_inv;

  logic [NUMWAYS-1:0] w_scan;
  logic [NUMWAYS-1:0] w_low;
  logic [NUMWAYS-1:0] w_rest;
  logic               w_last;

  // Two's-complement trick isolates the lowest pending way.
  assign w_scan = ValidWay & DirtyWay;
  assign w_low  = r_pending & (~r_pending + c_WAY_ONE);
  assign w_rest = r_pending & ~w_low;
  assign w_last = (r_set == c_LAST_SET);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_set     <= '0;
      r_pending <= '0;
      r_inv     <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (FlushStart) begin
            r_inv <= InvalidateMode;
            r_set <= '0;
          end
        end
        S_SCAN:   r_pending <= w_scan;
        S_WB: begin
          if (WBAck) r_pending <= w_rest;
        end
        S_FINISH: begin
          if (!w_last) r_set <= r_set + c_SET_ONE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next      = r_state;
    FlushAdr    = '0;
    FlushAdrSel = 1'b0;
    CacheEn     = 1'b0;
    FlushWay    = '0;
    WBReq       = 1'b0;
    ClearDirty  = 1'b0;
    ClearValid  = 1'b0;
    Busy        = 1'b0;
    FlushDone   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (FlushStart) w_next = S_READ;
      end
      S_READ: begin
        CacheEn = 1'b1;
        w_next  = S_SCAN;
      end
      S_SCAN: begin
        w_next = (w_scan == '0) ? S_FINISH : S_WB;
      end
      S_WB: begin
        FlushWay = w_low;
        WBReq    = 1'b1;
        if (WBAck) begin
          ClearDirty = 1'b1;
          if (w_rest == '0) w_next = S_FINISH;
        end
      end
      S_FINISH: begin
        if (r_inv) begin
          ClearValid = 1'b1;
          FlushWay   = '1;
        end
        w_next = w_last ? S_DONE : S_READ;
      end
      S_DONE: begin
        FlushDone = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // The array mux stays on the walker for the whole walk, not just READ.
    if (r_state != S_IDLE) begin
      Busy        = 1'b1;
      FlushAdrSel = 1'b1;
      FlushAdr    = r_set;
    end
  end

`ifdef CACHE_FLUSH_WBCOUNT_EN
  logic [15:0] r_wbcount;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wbcount <= '0;
    end else if (r_state == S_IDLE && FlushStart) begin
      r_wbcount <= '0;
    end else if (r_state == S_WB && WBAck && r_wbcount != 16'hFFFF) begin
      r_wbcount <= r_wbcount + 16'd1;
    end
  end

  assign WBCount = r_wbcount;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_flush_walker.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_flush_walker
// Brief    : Scoreboard bench: a cache-array model feeds the walker, expected
//            writeback/invalidate/done events are queued at each start.
// Revision : 1.0  initial release
// ============================================================================
module tb_cache_flush_walker;
  localparam int NW = 4;
  localparam int SL = 3;
  localparam int NL = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          FlushStart = 1'b0;
  logic          InvalidateMode = 1'b0;
  logic [NW-1:0] ValidWay = '0;
  logic [NW-1:0] DirtyWay = '0;
  logic          WBAck = 1'b0;
  logic [SL-1:0] FlushAdr;
  logic          FlushAdrSel, CacheEn, WBReq, ClearDirty, ClearValid, Busy, FlushDone;
  logic [NW-1:0] FlushWay;
`ifdef CACHE_FLUSH_WBCOUNT_EN
  logic [15:0]   WBCount;
`endif

  cache_flush_walker #(.NUMWAYS(NW), .SETLEN(SL), .NUMLINES(NL)) dut (
    .clk(clk), .reset(reset), .FlushStart(FlushStart), .InvalidateMode(InvalidateMode),
    .ValidWay(ValidWay), .DirtyWay(DirtyWay), .WBAck(WBAck),
    .FlushAdr(FlushAdr), .FlushAdrSel(FlushAdrSel), .CacheEn(CacheEn), .FlushWay(FlushWay),
    .WBReq(WBReq), .ClearDirty(ClearDirty), .ClearValid(ClearValid), .Busy(Busy),
    .FlushDone(FlushDone)
`ifdef CACHE_FLUSH_WBCOUNT_EN
    , .WBCount(WBCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int            kind;   // 0 writeback, 1 invalidate, 2 done
    int            adr;
    logic [NW-1:0] way;
  } ev_t;

  logic [NW-1:0] c_valid [NL];
  logic [NW-1:0] c_dirty [NL];
  ev_t           exp_q[$];
  int            n_pass = 0;
  int            n_total = 0;
  int            ack_fixed = -1;
  bit            mon_armed = 0;
  int            cyc = 0;
  int            wbcyc = 0;
  int            rd_idx = 0;
  int            exp_wbcount = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int pick();
    if (ack_fixed < 0) return int'($urandom_range(3, 0));
    return ack_fixed;
  endfunction

  // Cache array (1-cycle read latency) and writeback-engine responder.
  initial begin
    bit pen;
    int padr, wcnt, wtgt;
    pen = 0; padr = 0; wcnt = 0; wtgt = 0;
    forever begin
      @(posedge clk); #1;
      if (pen && padr < NL) begin
        ValidWay = c_valid[padr];
        DirtyWay = c_dirty[padr];
      end else begin
        ValidWay = NW'($urandom);
        DirtyWay = NW'($urandom);
      end
      pen  = CacheEn;
      padr = int'(FlushAdr);
      if (WBReq) begin
        if (wcnt >= wtgt) begin
          WBAck = 1'b1; wcnt = 0; wtgt = pick();
        end else begin
          WBAck = 1'b0; wcnt++;
        end
      end else begin
        WBAck = 1'($urandom);
        wcnt = 0;
        wtgt = pick();
      end
    end
  end

  task automatic pop_cmp(int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_event: got kind %0d adr %0d way %b, expected none", kind, FlushAdr, FlushWay);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (kind != 2) begin
        check("event_adr", FlushAdr, e.adr);
        check("event_way", FlushWay, e.way);
      end
    end
  endtask

  // Monitor: pops expected events as the DUT presents them.
  initial begin
    logic          pw, pcd;
    logic [NW-1:0] pway;
    pw = 0; pcd = 0; pway = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_armed = 0; pw = 0; pcd = 0;
      end else begin
        if (mon_armed) begin
          cyc++;
          if (WBReq) wbcyc++;
          if (CacheEn) begin
            check("read_adr", FlushAdr, rd_idx);
            rd_idx++;
          end
        end
        if (ClearDirty || ClearValid) check("clear_exclusive", ClearDirty & ClearValid, 0);
        if (pw && !pcd) begin
          check("wbreq_hold", WBReq, 1);
          check("flushway_hold", FlushWay, pway);
        end
        if (ClearDirty) begin
          pop_cmp(0);
          if (FlushAdr < NL) c_dirty[FlushAdr] &= ~FlushWay;
        end
        if (ClearValid) begin
          pop_cmp(1);
          if (FlushAdr < NL) c_valid[FlushAdr] &= ~FlushWay;
        end
        if (FlushDone) begin
          pop_cmp(2);
          check("walk_cycles", cyc, 3 * NL + wbcyc + 1);
          check("queue_empty", exp_q.size(), 0);
          mon_armed = 0;
        end
        if (!Busy && FlushStart) begin
          mon_armed = 1; cyc = 0; wbcyc = 0; rd_idx = 0;
        end
        pw = WBReq; pcd = ClearDirty; pway = FlushWay;
      end
    end
  end

  task automatic start_walk(bit inv);
    ev_t e;
    @(posedge clk); #1;
    exp_wbcount = 0;
    for (int s = 0; s < NL; s++) begin
      for (int w = 0; w < NW; w++) begin
        if (c_valid[s][w] && c_dirty[s][w]) begin
          e.kind = 0; e.adr = s; e.way = NW'(1 << w);
          exp_q.push_back(e);
          exp_wbcount++;
        end
      end
      if (inv) begin
        e.kind = 1; e.adr = s; e.way = '1;
        exp_q.push_back(e);
      end
    end
    e.kind = 2; e.adr = 0; e.way = '0;
    exp_q.push_back(e);
    InvalidateMode = inv;
    FlushStart = 1'b1;
    @(posedge clk); #1;
    FlushStart = 1'b0;
    InvalidateMode = 1'($urandom);
    check("start_latency", {Busy, CacheEn, FlushAdrSel}, 3'b111);
`ifdef CACHE_FLUSH_WBCOUNT_EN
    check("wbcount_cleared", WBCount, 0);
`endif
  endtask

  task automatic wait_done(bit noisy);
    bit got;
    got = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (FlushDone) begin
        got = 1;
        FlushStart = 1'b0;
        break;
      end
      FlushStart = noisy && Busy && ($urandom_range(3, 0) == 0);
      InvalidateMode = 1'($urandom);
    end
    check("done_seen", got, 1);
    @(posedge clk); #1;
    check("idle_after_done", {Busy, FlushDone}, 2'b00);
`ifdef CACHE_FLUSH_WBCOUNT_EN
    check("wbcount_final", WBCount, exp_wbcount);
`endif
  endtask

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {FlushAdr, FlushAdrSel, CacheEn, FlushWay, WBReq, ClearDirty,
                            ClearValid, Busy, FlushDone}, 0);
`ifdef CACHE_FLUSH_WBCOUNT_EN
    check("reset_wbcount", WBCount, 0);
`endif
    reset = 1'b0;

    // Clean cache, no invalidate, start re-asserted while busy.
    for (int s = 0; s < NL; s++) begin c_valid[s] = NW'($urandom); c_dirty[s] = '0; end
    start_walk(0);
    wait_done(1);

    // Set 2 holds two dirty valid ways, ack two cycles after each request.
    for (int s = 0; s < NL; s++) begin c_valid[s] = '0; c_dirty[s] = '0; end
    c_valid[2] = 4'b1011; c_dirty[2] = 4'b1110;
    ack_fixed = 2;
    start_walk(0);
    wait_done(0);
    ack_fixed = -1;

    // Invalidate a clean cache.
    for (int s = 0; s < NL; s++) begin c_valid[s] = '1; c_dirty[s] = '0; end
    start_walk(1);
    wait_done(1);

    // Random contents, modes and ack delays.
    for (int it = 0; it < 8; it++) begin
      for (int s = 0; s < NL; s++) begin c_valid[s] = NW'($urandom); c_dirty[s] = NW'($urandom); end
      start_walk(1'($urandom));
      wait_done(1);
    end

    // Reset while a writeback is waiting on its ack.
    for (int s = 0; s < NL; s++) begin c_valid[s] = '1; c_dirty[s] = '1; end
    ack_fixed = 1000;
    start_walk(0);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (WBReq) begin seen = 1; break; end
    end
    check("wb_reached", seen, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midwalk_reset_outputs", {FlushAdr, FlushAdrSel, CacheEn, FlushWay, WBReq, ClearDirty,
                                    ClearValid, Busy, FlushDone}, 0);
    exp_q.delete();
    ack_fixed = -1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (FlushDone) seen = 1;
    end
    check("no_done_after_reset", seen, 0);
    start_walk(0);
    wait_done(1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
